// File: rtl/wb_cpu_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM encodings, Wishbone CTI/BTE codes and
// the bundled master request record used by the system-bus arbiter.
package wb_cpu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
    localparam logic [2:0] CTI_INCR_BURST   = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [29:0] addr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic [31:0] data;
    } wb_req_t;

    // On a tie the master that was not granted last wins.
    function automatic arb_state_t tie_winner(input logic last_gnt);
        return last_gnt ? ST_GNT0 : ST_GNT1;
    endfunction

endpackage

// File: rtl/wb_cpu_arbiter_timeout_cnt.sv
// Slave-ack wait counter: counts strobe cycles without an ack and flags when
// the count reaches TIMEOUT.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == LIMIT);

endmodule

// File: rtl/wb_cpu_arbiter.sv
// Two-master (ICMU = m0, DCMU = m1) Wishbone arbiter onto the shared system
// bus: round-robin on ties, grant held for whole cycles, forced response on timeout.
module wb_cpu_arbiter
    import wb_cpu_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int RR_INIT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:2] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:2] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:2] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic        timeout_o
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_last;

    wb_req_t    w_m0;
    wb_req_t    w_m1;
    wb_req_t    w_req;
    logic       w_hit;
    logic       w_timeout;
    logic       w_cnt_clr;
    logic       w_cnt_inc;

    assign w_m0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, addr: m0_addr_i,
                    cti: m0_cti_i, bte: m0_bte_i, sel: m0_sel_i, data: m0_data_i};
    assign w_m1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, addr: m1_addr_i,
                    cti: m1_cti_i, bte: m1_bte_i, sel: m1_sel_i, data: m1_data_i};

    always_comb begin
        w_req = '0;
        case (r_state)
            ST_GNT0: w_req = w_m0;
            ST_GNT1: w_req = w_m1;
            default: w_req = '0;
        endcase
    end

    // A forced response is only owed to a live strobe; a real ack in the same
    // cycle wins.
    assign w_timeout = w_hit & w_req.stb & ~s_ack_i;

    assign s_cyc_o  = w_req.cyc & ~w_timeout;
    assign s_stb_o  = w_req.stb & ~w_timeout;
    assign s_we_o   = w_req.we;
    assign s_addr_o = w_req.addr;
    assign s_cti_o  = w_req.cti;
    assign s_bte_o  = w_req.bte;
    assign s_sel_o  = w_req.sel;
    assign s_data_o = w_req.data;

    assign m0_ack_o  = (r_state == ST_GNT0) & (s_ack_i | w_timeout);
    assign m1_ack_o  = (r_state == ST_GNT1) & (s_ack_i | w_timeout);
    assign m0_data_o = ((r_state == ST_GNT0) && !w_timeout) ? s_data_i : '0;
    assign m1_data_o = ((r_state == ST_GNT1) && !w_timeout) ? s_data_i : '0;
    assign timeout_o = w_timeout;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_state_next = tie_winner(r_last);
                else if (m0_cyc_i)        w_state_next = ST_GNT0;
                else if (m1_cyc_i)        w_state_next = ST_GNT1;
            end
            ST_GNT0: begin
                if (w_timeout)     w_state_next = ST_IDLE;
                else if (!m0_cyc_i) w_state_next = m1_cyc_i ? ST_GNT1 : ST_IDLE;
            end
            ST_GNT1: begin
                if (w_timeout)     w_state_next = ST_IDLE;
                else if (!m1_cyc_i) w_state_next = m0_cyc_i ? ST_GNT0 : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_last tracks the master of the latest grant, so after a timeout it
    // already names the timed-out master.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= RR_INIT[0];
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ST_GNT0)      r_last <= 1'b0;
            else if (w_state_next == ST_GNT1) r_last <= 1'b1;
        end
    end

    assign w_cnt_clr = s_ack_i | ~w_req.stb | (w_state_next != r_state);
    assign w_cnt_inc = w_req.stb & ~s_ack_i;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_hit (w_hit)
    );

endmodule

// File: tb/tb_wb_cpu_arbiter.sv
// Directed bench for wb_cpu_arbiter: a vector table for grant/pass-through
// behaviour plus hand sequences for bursts, timeout and reset.
module tb_wb_cpu_arbiter;
    import wb_cpu_arbiter_pkg::*;

    localparam logic [29:0] M0_ADDR = 30'h80;  // byte 0x200
    localparam logic [29:0] M1_ADDR = 30'h40;  // byte 0x100
    localparam logic [3:0]  M0_SEL  = 4'hF;
    localparam logic [3:0]  M1_SEL  = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:2] m0_addr_i;
    logic [2:0]  m0_cti_i;
    logic [1:0]  m0_bte_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_i, m0_data_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:2] m1_addr_i;
    logic [2:0]  m1_cti_i;
    logic [1:0]  m1_bte_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_i, m1_data_o;
    logic        m1_ack_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:2] s_addr_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_o, s_data_i;
    logic        s_ack_i;
    logic        timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_cpu_arbiter #(.TIMEOUT(255), .RR_INIT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .timeout_o(timeout_o)
    );

    typedef struct {
        logic        c0;
        logic        c1;
        logic        ack;
        logic [31:0] data;
        logic        e_scyc;
        logic [1:0]  e_g;     // 0 idle, 1 m0 granted, 2 m1 granted
        logic        e_ack0;
        logic        e_ack1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cyc(input logic c0, input logic c1);
        m0_cyc_i = c0; m0_stb_i = c0;
        m1_cyc_i = c1; m1_stb_i = c1;
    endtask

    function automatic logic [29:0] exp_addr(input logic [1:0] g);
        return (g == 2'd1) ? M0_ADDR : (g == 2'd2) ? M1_ADDR : 30'h0;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] g);
        return (g == 2'd1) ? M0_SEL : (g == 2'd2) ? M1_SEL : 4'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;

        rst = 1'b1;
        m0_we_i = 1'b0; m0_addr_i = M0_ADDR; m0_cti_i = CTI_CLASSIC; m0_bte_i = BTE_LINEAR;
        m0_sel_i = M0_SEL; m0_data_i = 32'h0000_00A0;
        m1_we_i = 1'b0; m1_addr_i = M1_ADDR; m1_cti_i = CTI_CLASSIC; m1_bte_i = BTE_LINEAR;
        m1_sel_i = M1_SEL; m1_data_i = 32'h0000_00A1;
        s_data_i = 32'h0; s_ack_i = 1'b1;
        drive_cyc(1'b1, 1'b0);

        // Reset held with a live request and a stray ack: nothing may pass.
        step(); step(); #1;
        chk("rst_scyc", 32'(s_cyc_o), 32'd0);
        chk("rst_ack0", 32'(m0_ack_o), 32'd0);
        chk("rst_to",   32'(timeout_o), 32'd0);
        chk("rst_sel",  32'(s_sel_o), 32'd0);
        rst = 1'b0; s_ack_i = 1'b0;
        drive_cyc(1'b0, 1'b0);

        // c0 c1 ack data         scyc g ack0 ack1
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h55,       1, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 2, 0, 0});
        vecs.push_back('{0, 1, 1, 32'hDEADBEEF, 1, 2, 0, 1});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 2, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h0,        0, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h0,        1, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 32'h11111111, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 2, 0, 0});
        vecs.push_back('{0, 1, 1, 32'h22222222, 1, 2, 0, 1});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 2, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h0,        0, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h0,        1, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 32'h33333333, 1, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0});

        foreach (vecs[i]) begin
            step();
            drive_cyc(vecs[i].c0, vecs[i].c1);
            s_ack_i = vecs[i].ack; s_data_i = vecs[i].data;
            #1;
            chk($sformatf("v%0d_scyc", i), 32'(s_cyc_o), 32'(vecs[i].e_scyc));
            chk($sformatf("v%0d_addr", i), 32'(s_addr_o), 32'(exp_addr(vecs[i].e_g)));
            chk($sformatf("v%0d_sel", i),  32'(s_sel_o), 32'(exp_sel(vecs[i].e_g)));
            chk($sformatf("v%0d_ack0", i), 32'(m0_ack_o), 32'(vecs[i].e_ack0));
            chk($sformatf("v%0d_ack1", i), 32'(m1_ack_o), 32'(vecs[i].e_ack1));
            chk($sformatf("v%0d_dat0", i), m0_data_o, (vecs[i].e_g == 2'd1) ? vecs[i].data : 32'h0);
            chk($sformatf("v%0d_dat1", i), m1_data_o, (vecs[i].e_g == 2'd2) ? vecs[i].data : 32'h0);
        end

        // Burst hold: m0 4-beat incrementing burst while m1 waits.
        step(); drive_cyc(1'b1, 1'b0); m0_cti_i = CTI_INCR_BURST; #1;
        chk("b_idle_scyc", 32'(s_cyc_o), 32'd0);
        for (int b = 0; b < 6; b++) begin
            step();
            drive_cyc(1'b1, 1'b1);
            s_ack_i  = (b != 0 && b != 3);
            s_data_i = 32'h1000 + 32'(b);
            m0_cti_i = (b == 5) ? CTI_END_OF_BURST : CTI_INCR_BURST;
            #1;
            chk($sformatf("b%0d_addr", b), 32'(s_addr_o), 32'(M0_ADDR));
            chk($sformatf("b%0d_cti", b),  32'(s_cti_o), 32'(m0_cti_i));
            chk($sformatf("b%0d_ack0", b), 32'(m0_ack_o), 32'(s_ack_i));
            chk($sformatf("b%0d_ack1", b), 32'(m1_ack_o), 32'd0);
        end
        step(); drive_cyc(1'b0, 1'b1); s_ack_i = 1'b0; m0_cti_i = CTI_CLASSIC; #1;
        chk("b_drop_scyc", 32'(s_cyc_o), 32'd0);
        step(); s_ack_i = 1'b1; s_data_i = 32'hA5A5A5A5; #1;
        chk("b_m1_scyc", 32'(s_cyc_o), 32'd1);
        chk("b_m1_addr", 32'(s_addr_o), 32'(M1_ADDR));
        chk("b_m1_ack",  32'(m1_ack_o), 32'd1);
        chk("b_m1_data", m1_data_o, 32'hA5A5A5A5);
        step(); drive_cyc(1'b0, 1'b0); s_ack_i = 1'b0;

        // Timeout: slave never acks m1.
        step(); drive_cyc(1'b0, 1'b1); s_data_i = 32'hCAFEF00D; #1;
        chk("to_idle0", 32'(s_cyc_o), 32'd0);
        quiet = 1'b1;
        for (int k = 0; k < 255; k++) begin
            step(); #1;
            if (s_cyc_o !== 1'b1 || m1_ack_o !== 1'b0 || timeout_o !== 1'b0) quiet = 1'b0;
        end
        chk("to_wait_quiet", 32'(quiet), 32'd1);
        step(); #1;
        chk("to_ack1",  32'(m1_ack_o), 32'd1);
        chk("to_data1", m1_data_o, 32'h0);
        chk("to_pulse", 32'(timeout_o), 32'd1);
        chk("to_scyc",  32'(s_cyc_o), 32'd0);
        chk("to_ack0",  32'(m0_ack_o), 32'd0);
        step(); drive_cyc(1'b1, 1'b1); #1;
        chk("to_back_idle", 32'(s_cyc_o), 32'd0);
        chk("to_once",      32'(timeout_o), 32'd0);
        chk("to_ack1_off",  32'(m1_ack_o), 32'd0);
        step(); #1;
        chk("to_tie_m0", 32'(s_addr_o), 32'(M0_ADDR));
        step(); drive_cyc(1'b0, 1'b0);

        // Ack exactly when the counter reaches the limit.
        step(); drive_cyc(1'b1, 1'b0); #1;
        quiet = 1'b1;
        for (int k = 0; k < 255; k++) begin
            step(); #1;
            if (m0_ack_o !== 1'b0 || timeout_o !== 1'b0) quiet = 1'b0;
        end
        chk("bd_wait_quiet", 32'(quiet), 32'd1);
        step(); s_ack_i = 1'b1; s_data_i = 32'h12345678; #1;
        chk("bd_ack0",  32'(m0_ack_o), 32'd1);
        chk("bd_data0", m0_data_o, 32'h12345678);
        chk("bd_to",    32'(timeout_o), 32'd0);
        chk("bd_scyc",  32'(s_cyc_o), 32'd1);
        step(); s_ack_i = 1'b0; drive_cyc(1'b0, 1'b0); #1;
        chk("bd_to_after", 32'(timeout_o), 32'd0);

        // Reset after the 2nd beat of an m0 burst.
        step(); drive_cyc(1'b1, 1'b0); m0_cti_i = CTI_INCR_BURST;
        step(); s_ack_i = 1'b1; #1;
        chk("rb_beat1", 32'(m0_ack_o), 32'd1);
        step(); #1;
        chk("rb_beat2", 32'(m0_ack_o), 32'd1);
        step(); s_ack_i = 1'b0; rst = 1'b1; drive_cyc(1'b1, 1'b1);
        step(); s_ack_i = 1'b1; #1;
        chk("rb_scyc", 32'(s_cyc_o), 32'd0);
        chk("rb_ack0", 32'(m0_ack_o), 32'd0);
        chk("rb_ack1", 32'(m1_ack_o), 32'd0);
        step(); rst = 1'b0; s_ack_i = 1'b0; #1;
        chk("rb_idle", 32'(s_cyc_o), 32'd0);
        step(); #1;
        chk("rb_tie_scyc", 32'(s_cyc_o), 32'd1);
        chk("rb_tie_m0",   32'(s_addr_o), 32'(M0_ADDR));
        step(); drive_cyc(1'b0, 1'b0); m0_cti_i = CTI_CLASSIC;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_cpu_arbiter.md
WB_CPU_ARBITER -- requirements
Module: wb_cpu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for a slave ack before the block forces a response.
REQ-002 SHALL have parameter RR_INIT, default 1: initial last-granted master after reset, so m0 (ICMU) wins the first tie.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports m0_cyc_i, m0_stb_i, m0_we_i, input, 1 each: ICMU master cycle, strobe and write-enable.
REQ-006 SHALL have ports m0_addr_i [31:2], m0_cti_i [2:0], m0_bte_i [1:0], m0_sel_i [3:0], m0_data_i [31:0], all inputs: ICMU request fields.
REQ-007 SHALL have ports m0_data_o [31:0] and m0_ack_o [1], outputs: ICMU read data and ack.
REQ-008 SHALL have m1_* ports identical to REQ-005..007: DCMU master.
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_addr_o [31:2], s_cti_o [2:0], s_bte_o [1:0], s_sel_o [3:0], s_data_o [31:0], all outputs: shared system bus.
REQ-010 SHALL have ports s_data_i [31:0] and s_ack_i [1], inputs: system bus response.
REQ-011 SHALL have port timeout_o, output, 1: one-cycle pulse when a forced response is issued.

Function
REQ-012 SHALL use a registered FSM with states IDLE, GNT0 and GNT1.
REQ-013 IDLE: if exactly one of m0_cyc_i/m1_cyc_i is high, next state is the matching GNT; if both are high, next state grants the master not granted last (round-robin).
REQ-014 GNTx: hold while mx_cyc_i is high, including whole bursts (cti 010) and locked sequences; no preemption.
REQ-015 GNTx with mx_cyc_i low: next state is GNTy if my_cyc_i is high, else IDLE.
REQ-016 Arbitration latency SHALL be 1 cycle from cyc assertion in IDLE to s_cyc_o high; switching between masters SHALL add no extra bubble.
REQ-017 In GNTx, all s_* outputs SHALL equal the mx_* inputs combinationally; mx_data_o = s_data_i and mx_ack_o = s_ack_i.
REQ-018 The non-granted master SHALL see ack_o=0 and data_o=0; in IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0 and s_sel_o SHALL be 0.
REQ-019 A wait counter (8 bits for the default TIMEOUT) SHALL clear on s_ack_i, on grant change and when stb is low, and SHALL increment each cycle that s_stb_o=1 and s_ack_i=0.
REQ-020 When the counter equals TIMEOUT, the block SHALL, in that cycle, drive mx_ack_o=1 and mx_data_o=32'h0 to the granted master, drive s_cyc_o=0, pulse timeout_o and go to IDLE.
REQ-021 A timeout SHALL record the timed-out master as last-granted.
REQ-022 An s_ack_i arriving in the same cycle as the timeout SHALL take precedence: normal ack, no timeout_o pulse.
REQ-023 A master dropping cyc mid-burst SHALL end its grant per REQ-015; the slave sees s_cyc_o fall in that cycle.

Reset
REQ-024 While rst is high: state=IDLE, last-granted=RR_INIT, counter=0, timeout_o=0, all acks 0 and s_cyc_o=0 from the next edge.
REQ-025 A reset asserted mid-transfer SHALL abort the transfer without producing an ack.

Structure
REQ-026 FSM state encodings and the Wishbone CTI/BTE constants SHALL live in the shared CPU define header.
REQ-027 The block SHALL contain one natural sub-module, wb_timeout_cnt (counter plus compare), instantiated once.
REQ-028 The block SHALL be instantiated between ICMU/DCMU and the system bus inside the CPU top.

Verification
REQ-029 Single request: m1 single read at 0x100, slave acks after 3 cycles with 0xDEADBEEF -> s_cyc_o high 1 cycle after m1_cyc_i; m1_ack_o=1 with 0xDEADBEEF; m0_ack_o stays 0.
REQ-030 Simultaneous requests after reset: both cyc high -> m0 granted first; on m0 release, m1 granted with no IDLE bubble; next tie -> m0 again.
REQ-031 Burst hold: m0 4-beat incrementing burst (cti 010...111) while m1 requests -> m1 not granted until m0_cyc_i falls after the 4th ack.
REQ-032 Timeout: slave never acks m1 -> after 255 wait cycles, m1_ack_o=1, data 0, timeout_o pulses once, state returns to IDLE.
REQ-033 Ack on the boundary: s_ack_i arrives exactly at count 255 -> normal data returned, timeout_o stays 0.
REQ-034 Reset mid-burst: rst after the 2nd beat -> s_cyc_o=0 next cycle, no further acks, m0 wins the next tie.
